// File: rtl/car_parking_fsm_pkg.sv
// rtl/car_parking_fsm_pkg.sv - shared state type and 7-segment glyphs for the parking gate
package car_parking_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  // Active-low segments, bit6..0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

endpackage

// File: rtl/car_parking_fsm.sv
// rtl/car_parking_fsm.sv - single-lane car park entrance gate controller
module car_parking_fsm
  import car_parking_fsm_pkg::*;
#(
  parameter logic [1:0] PASS1       = 2'b01,
  parameter logic [1:0] PASS2       = 2'b10,
  parameter int         WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Front_Sensor,
  input  logic       Back_Sensor,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       pass_ok;
  logic       green_next, red_next;
  logic [6:0] hex_1_next, hex_2_next;

  assign pass_ok = (password_1 == PASS1) && (password_2 == PASS2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (Front_Sensor) state_next = WAIT_PASSWORD;
      WAIT_PASSWORD: if (wait_cnt == WAIT_LAST) state_next = pass_ok ? RIGHT_PASS : WRONG_PASS;
      WRONG_PASS:    if (pass_ok) state_next = RIGHT_PASS;
      RIGHT_PASS: begin
        if (Front_Sensor && Back_Sensor)
          state_next = STOP;
        else if (Back_Sensor)
          state_next = IDLE;
      end
      STOP:          if (pass_ok) state_next = RIGHT_PASS;
      default:       state_next = IDLE;
    endcase
  end

  // Output decode uses the current state, so displays lag the state by one clock
  always_comb begin
    green_next = 1'b0;
    red_next   = 1'b0;
    hex_1_next = SEG_BLANK;
    hex_2_next = SEG_BLANK;
    case (state)
      WAIT_PASSWORD: begin
        red_next   = 1'b1;
        hex_1_next = SEG_E;
        hex_2_next = SEG_N;
      end
      WRONG_PASS: begin
        red_next   = ~RED_LED;
        hex_1_next = SEG_E;
        hex_2_next = SEG_E;
      end
      RIGHT_PASS: begin
        green_next = ~GREEN_LED;
        hex_1_next = SEG_6;
        hex_2_next = SEG_0;
      end
      STOP: begin
        red_next   = ~RED_LED;
        hex_1_next = SEG_5;
        hex_2_next = SEG_P;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= SEG_BLANK;
      HEX_2     <= SEG_BLANK;
    end else begin
      state     <= state_next;
      wait_cnt  <= (state == WAIT_PASSWORD) ? wait_cnt + 4'd1 : 4'd0;
      GREEN_LED <= green_next;
      RED_LED   <= red_next;
      HEX_1     <= hex_1_next;
      HEX_2     <= hex_2_next;
    end
  end

endmodule

// File: tb/tb_car_parking_fsm.sv
// tb/tb_car_parking_fsm.sv - randomized self-checking bench for car_parking_fsm
module tb_car_parking_fsm;

  localparam int WC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       front = 1'b0, back = 1'b0;
  logic [1:0] pw1 = 2'b00, pw2 = 2'b00;
  logic       green, red;
  logic [6:0] hex_1, hex_2;

  car_parking_fsm #(.PASS1(2'b01), .PASS2(2'b10), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset_n(reset_n), .Front_Sensor(front), .Back_Sensor(back),
    .password_1(pw1), .password_2(pw2),
    .GREEN_LED(green), .RED_LED(red), .HEX_1(hex_1), .HEX_2(hex_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: gate phase, remaining wait clocks, and the visible outputs
  localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_RIGHT = 3, M_STOP = 4;
  int         m_mode;
  int         m_wait_left;
  logic       e_green, e_red;
  logic [6:0] e_hex_1, e_hex_2;

  task automatic model_reset();
    m_mode = M_IDLE; m_wait_left = 0;
    e_green = 1'b0; e_red = 1'b0; e_hex_1 = 7'b1111111; e_hex_2 = 7'b1111111;
  endtask

  task automatic model_clock(input logic f, input logic b, input logic [1:0] p1, input logic [1:0] p2);
    bit ok;
    ok = (p1 == 2'd1) && (p2 == 2'd2);
    case (m_mode)
      M_IDLE:  begin e_green = 0;        e_red = 0;       e_hex_1 = 7'b1111111; e_hex_2 = 7'b1111111; end
      M_WAIT:  begin e_green = 0;        e_red = 1;       e_hex_1 = 7'b0000110; e_hex_2 = 7'b0101011; end
      M_WRONG: begin e_green = 0;        e_red = !e_red;  e_hex_1 = 7'b0000110; e_hex_2 = 7'b0000110; end
      M_RIGHT: begin e_green = !e_green; e_red = 0;       e_hex_1 = 7'b0000010; e_hex_2 = 7'b1000000; end
      default: begin e_green = 0;        e_red = !e_red;  e_hex_1 = 7'b0010010; e_hex_2 = 7'b0001100; end
    endcase
    case (m_mode)
      M_IDLE: if (f) begin m_mode = M_WAIT; m_wait_left = WC; end
      M_WAIT: begin
        m_wait_left--;
        if (m_wait_left == 0) m_mode = ok ? M_RIGHT : M_WRONG;
      end
      M_WRONG, M_STOP: if (ok) m_mode = M_RIGHT;
      default: if (f && b) m_mode = M_STOP; else if (b) m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".green"}, {7'b0, green}, {7'b0, e_green});
    check({tag, ".red"},   {7'b0, red},   {7'b0, e_red});
    check({tag, ".hex_1"}, {1'b0, hex_1}, {1'b0, e_hex_1});
    check({tag, ".hex_2"}, {1'b0, hex_2}, {1'b0, e_hex_2});
  endtask

  task automatic step(input string tag, input logic f, input logic b, input logic [1:0] p1, input logic [1:0] p2);
    front = f; back = b; pw1 = p1; pw2 = p2;
    @(posedge clk);
    #1;
    model_clock(f, b, p1, p2);
    check_outputs(tag);
  endtask

  // Async reset between edges: outputs must clear with no clock
  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_outputs(tag);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    repeat (1 + WC + 4) step("wrong_pw", 1, 0, 2'd0, 2'd0);
    repeat (4) step("recover", 0, 0, 2'd1, 2'd2);
    step("car_pass", 0, 1, 2'd1, 2'd2);
    repeat (2) step("idle", 0, 0, 2'd0, 2'd0);
    repeat (1 + WC + 3) step("right_pw", 1, 0, 2'd1, 2'd2);
    repeat (6) step("tailgate", 1, 1, 2'd1, 2'd2);
    repeat (3) step("hold", 0, 0, 2'd1, 2'd2);
    check("in_right_pass", {7'b0, (m_mode == M_RIGHT)}, 8'd1);
    reset_pulse("reset_mid_right");

    for (int i = 0; i < 600; i++) begin
      logic       f, b;
      logic [1:0] p1, p2;
      f = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin p1 = 2'd1; p2 = 2'd2; end
      else begin p1 = 2'($urandom); p2 = 2'($urandom); end
      step("random", f, b, p1, p2);
      if ($urandom_range(0, 99) == 0) reset_pulse("random_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
